credit_tx_bridge: RTL and testbench
===================================

CREDIT_TX_BRIDGE -- requirements
Module: credit_tx_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128: data beat width in bits.
REQ-002 The block SHALL have parameter EMPTY_W, default 4: empty-field width in bits.
REQ-003 The block SHALL have parameter CHAN_W, default 10: channel-field width in bits.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 32: buffer depth in beats, a power of 2 and >= 4.
REQ-005 The block SHALL have parameter CREDIT_W, default 8: credit counter width in bits.
REQ-006 The block SHALL have parameter MAX_CREDIT, default 255: credit saturation limit, <= 2^CREDIT_W-1.
REQ-007 The block SHALL have parameter IDLE_CYC, default 16: consecutive idle cycles before unused credits are returned; 0 disables return.
REQ-008 Ports SHALL be exactly (name, direction, width, meaning):
  clk  in  1  clock, all logic rising-edge
  reset_n  in  1  reset, asynchronous, active-low
  avsi_channel/avsi_data/avsi_sop/avsi_eop/avsi_empty  in  CHAN_W/DATA_W/1/1/EMPTY_W  ready/valid sink beat fields
  avsi_valid  in  1  sink valid
  avsi_ready  out  1  sink ready
  update_credit  in  1  credit grant strobe from downstream
  credit  in  CREDIT_W  number of credits granted with update_credit
  return_credit  out  1  one-credit return pulse to downstream
  avso_channel/avso_data/avso_sop/avso_eop/avso_empty  out  CHAN_W/DATA_W/1/1/EMPTY_W  credit source beat fields
  avso_valid  out  1  source valid, no backpressure
  credit_count  out  CREDIT_W  current credit balance
  fifo_level  out  clog2(FIFO_DEPTH)+1  beats buffered
  credit_ovf  out  1  sticky credit-overflow error
  err_clr  in  1  clears credit_ovf

Function
REQ-009 A beat SHALL be accepted when avsi_valid & avsi_ready; avsi_valid while avsi_ready=0 SHALL be ignored.
REQ-010 avsi_ready SHALL be registered and SHALL equal (next-cycle fifo_level < FIFO_DEPTH), so no accepted beat is ever lost.
REQ-011 The stored empty field SHALL be avsi_empty when avsi_eop=1, otherwise 0.
REQ-012 A pop SHALL occur in a cycle where FIFO is non-empty and registered credit_count > 0; one pop per cycle maximum.
REQ-013 A popped beat SHALL appear on avso_* with avso_valid=1 exactly one cycle after the pop; avso_valid SHALL be 0 in all other cycles; minimum accept-to-avso_valid latency SHALL be 2 cycles.
REQ-014 Credit update per cycle SHALL be: grant only +credit; pop only -1; grant and pop +credit-1; idle return -1; none unchanged.
REQ-015 Arithmetic SHALL be done at CREDIT_W+1 bits; a result > MAX_CREDIT SHALL clamp to MAX_CREDIT and set credit_ovf.
REQ-016 update_credit with credit=0 SHALL be a no-op.
REQ-017 credit_ovf SHALL stay set until err_clr=1; simultaneous set and err_clr SHALL leave it set.
REQ-018 An idle counter SHALL count cycles with FIFO empty, no acceptance and no update_credit, and SHALL reset to 0 otherwise.
REQ-019 When IDLE_CYC>0, idle counter >= IDLE_CYC and credit_count > 0, the block SHALL decrement credit_count by 1 and pulse return_credit for one cycle, once per cycle until credit_count=0 or idle ends.
REQ-020 return_credit and a pop SHALL never occur in the same cycle.
REQ-021 Beat order SHALL be preserved; sop/eop are passed through unchecked.

Reset
REQ-022 While reset_n=0: avsi_ready=0, avso_valid=0, avso_* fields=0, return_credit=0, credit_count=0, fifo_level=0, credit_ovf=0, idle counter=0, FIFO empty.
REQ-023 avsi_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-024 Reset mid-packet SHALL discard all buffered beats and credits; no partial output SHALL follow reset.

Structure
REQ-025 Package credit_pkg SHALL hold the credit-update encoding constants and a saturating-add function shared with the credit-receive block.
REQ-026 Buffering SHALL be a sub-module sync_fifo_fwft (first-word-fall-through, parametrised width/depth, level output); credit and idle logic SHALL stay in the top module.

Verification
REQ-027 Credits 0, push 3 beats: avso_valid stays 0; grant credit=2 -> exactly 2 beats out on consecutive cycles, credit_count=0, fifo_level=1.
REQ-028 Grant credit=40, push 40 beats with FIFO_DEPTH=32 at full rate: avsi_ready deasserts at level 32, all 40 beats out in order, no loss.
REQ-029 Grant 200 then 100 with MAX_CREDIT=255: credit_count=255, credit_ovf=1; err_clr pulse -> credit_ovf=0.
REQ-030 Grant 5, FIFO empty, IDLE_CYC=16: after 16 idle cycles return_credit pulses 5 consecutive cycles, credit_count reaches 0.
REQ-031 Grant and pop in the same cycle with credit_count=1, credit=3: credit_count=3 next cycle.
REQ-032 Assert reset_n=0 with 10 beats buffered: all outputs 0; after release, nothing is emitted until new beats and credits arrive.

Source files
------------

// File: rtl/credit_pkg.sv
// rtl/credit_pkg.sv - credit update encoding and saturating arithmetic shared by credit blocks
package credit_pkg;

  typedef enum logic [2:0] {
    CU_NONE      = 3'd0,
    CU_GRANT     = 3'd1,
    CU_POP       = 3'd2,
    CU_GRANT_POP = 3'd3,
    CU_RETURN    = 3'd4
  } cu_t;

  // Returns {overflow, result}; result is clamped to max_val when base+add-dec exceeds it.
  function automatic logic [32:0] sat_add(input logic [31:0] base, input logic [31:0] add,
                                          input logic dec, input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, base} + {1'b0, add} - {32'd0, dec};
    if (sum > {1'b0, max_val}) return {1'b1, max_val};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with occupancy level
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (level == '0);

endmodule

// File: rtl/credit_tx_bridge.sv
// rtl/credit_tx_bridge.sv - ready/valid sink to credit-based source bridge with idle credit return
module credit_tx_bridge
  import credit_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int EMPTY_W    = 4,
  parameter int CHAN_W     = 10,
  parameter int FIFO_DEPTH = 32,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 255,
  parameter int IDLE_CYC   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [CHAN_W-1:0]           avsi_channel,
  input  logic [DATA_W-1:0]           avsi_data,
  input  logic                        avsi_sop,
  input  logic                        avsi_eop,
  input  logic [EMPTY_W-1:0]          avsi_empty,
  input  logic                        avsi_valid,
  output logic                        avsi_ready,
  input  logic                        update_credit,
  input  logic [CREDIT_W-1:0]         credit,
  output logic                        return_credit,
  output logic [CHAN_W-1:0]           avso_channel,
  output logic [DATA_W-1:0]           avso_data,
  output logic                        avso_sop,
  output logic                        avso_eop,
  output logic [EMPTY_W-1:0]          avso_empty,
  output logic                        avso_valid,
  output logic [CREDIT_W-1:0]         credit_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        credit_ovf,
  input  logic                        err_clr
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = CHAN_W + DATA_W + 2 + EMPTY_W;
  localparam int IW = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;

  logic                push, pop, ret, grant, idle_now, empty;
  logic [BW-1:0]       push_data, pop_data;
  logic [LW-1:0]       level_next;
  logic [IW-1:0]       idle_cnt;
  cu_t                 cu;
  logic [32:0]         sat;
  logic [CREDIT_W-1:0] count_next;
  logic                ovf_set;

  assign push      = avsi_valid & avsi_ready;
  assign push_data = {avsi_channel, avsi_data, avsi_sop, avsi_eop,
                      avsi_eop ? avsi_empty : {EMPTY_W{1'b0}}};
  assign grant     = update_credit && (credit != '0);
  assign idle_now  = empty && !push && !update_credit;
  assign ret       = (IDLE_CYC > 0) && idle_now && (idle_cnt >= IW'(IDLE_CYC)) &&
                     (credit_count != '0);
  assign pop       = !empty && (credit_count != '0) && !ret;
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  sync_fifo_fwft #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    cu = CU_NONE;
    if (grant && pop) cu = CU_GRANT_POP;
    else if (grant)   cu = CU_GRANT;
    else if (pop)     cu = CU_POP;
    else if (ret)     cu = CU_RETURN;
    sat = sat_add(32'(credit_count),
                  (cu inside {CU_GRANT, CU_GRANT_POP}) ? 32'(credit) : 32'd0,
                  cu inside {CU_POP, CU_GRANT_POP, CU_RETURN},
                  32'(MAX_CREDIT));
    count_next = sat[CREDIT_W-1:0];
    // Bits above CREDIT_W are always zero once the result is clamped to MAX_CREDIT.
    ovf_set    = sat[32] | (|sat[31:CREDIT_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (!idle_now) begin
      idle_cnt <= '0;
    end else if (idle_cnt < IW'(IDLE_CYC)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avsi_ready    <= 1'b0;
      credit_count  <= '0;
      credit_ovf    <= 1'b0;
      return_credit <= 1'b0;
      avso_valid    <= 1'b0;
      avso_channel  <= '0;
      avso_data     <= '0;
      avso_sop      <= 1'b0;
      avso_eop      <= 1'b0;
      avso_empty    <= '0;
    end else begin
      avsi_ready    <= (level_next < LW'(FIFO_DEPTH));
      credit_count  <= count_next;
      credit_ovf    <= ovf_set | (credit_ovf & ~err_clr);
      return_credit <= ret;
      avso_valid    <= pop;
      if (pop) {avso_channel, avso_data, avso_sop, avso_eop, avso_empty} <= pop_data;
    end
  end

endmodule

// File: tb/tb_credit_tx_bridge.sv
// tb/tb_credit_tx_bridge.sv - directed self-checking bench for credit_tx_bridge
module tb_credit_tx_bridge;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   avsi_channel;
  logic [127:0] avsi_data;
  logic         avsi_sop, avsi_eop;
  logic [3:0]   avsi_empty;
  logic         avsi_valid;
  logic         avsi_ready;
  logic         update_credit;
  logic [7:0]   credit;
  logic         return_credit;
  logic [9:0]   avso_channel;
  logic [127:0] avso_data;
  logic         avso_sop, avso_eop;
  logic [3:0]   avso_empty;
  logic         avso_valid;
  logic [7:0]   credit_count;
  logic [5:0]   fifo_level;
  logic         credit_ovf;
  logic         err_clr;

  credit_tx_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .avsi_channel(avsi_channel), .avsi_data(avsi_data), .avsi_sop(avsi_sop),
    .avsi_eop(avsi_eop), .avsi_empty(avsi_empty), .avsi_valid(avsi_valid),
    .avsi_ready(avsi_ready), .update_credit(update_credit), .credit(credit),
    .return_credit(return_credit), .avso_channel(avso_channel), .avso_data(avso_data),
    .avso_sop(avso_sop), .avso_eop(avso_eop), .avso_empty(avso_empty),
    .avso_valid(avso_valid), .credit_count(credit_count), .fifo_level(fifo_level),
    .credit_ovf(credit_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       upd;
    logic [7:0] cr;
    logic       clr;
    logic [7:0] exp_cnt;
    logic       exp_ovf;
  } vec_t;

  vec_t         tbl [10];
  logic [143:0] q [$];
  int n_cmp = 0, n_err = 0, cnum = 0, seq = 0, push_left = 0;
  int n_out = 0, first_out = -1, last_out = -1, last_acc = -1;
  int ret_cnt = 0, first_ret = -1, last_ret = -1, g = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_beat(input int s);
    avsi_channel = 10'(s);
    avsi_data    = {96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'(s)};
    avsi_sop     = (s % 4 == 0);
    avsi_eop     = (s % 4 == 3);
    avsi_empty   = 4'((s * 3) % 16);
  endtask

  function automatic logic [143:0] exp_beat(input int s);
    logic       eop;
    logic [3:0] emp;
    eop = (s % 4 == 3);
    emp = eop ? 4'((s * 3) % 16) : 4'd0;
    return {10'(s), 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'(s), (s % 4 == 0), eop, emp};
  endfunction

  // One clock: note acceptance before the edge, then observe outputs 1ns after it.
  task automatic cyc();
    logic         acc;
    logic [143:0] act;
    acc = avsi_valid && avsi_ready && reset_n;
    @(posedge clk);
    #1;
    cnum++;
    if (acc) begin
      q.push_back(exp_beat(seq));
      last_acc = cnum;
      seq++;
      push_left--;
      set_beat(seq);
      if (push_left <= 0) avsi_valid = 1'b0;
    end
    if (avso_valid) begin
      act = {avso_channel, avso_data, avso_sop, avso_eop, avso_empty};
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h expected none", act);
      end else begin
        chk("beat_order", act, q.pop_front());
      end
      n_out++;
      if (first_out < 0) first_out = cnum;
      last_out = cnum;
    end
    if (return_credit) begin
      ret_cnt++;
      if (first_ret < 0) first_ret = cnum;
      last_ret = cnum;
    end
    if (fifo_level > 6'd32) chk("fifo_bound", 144'(fifo_level), 144'd32);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, 144'(avsi_ready), 144'd0);
    chk({tag, "_avso"}, {avso_valid, avso_channel, avso_data, avso_sop, avso_eop, avso_empty}, 144'd0);
    chk({tag, "_ret_cnt_ovf"}, {return_credit, credit_count, credit_ovf}, 144'd0);
    chk({tag, "_level"}, 144'(fifo_level), 144'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    avsi_valid = 1'b0; update_credit = 1'b0; credit = '0; err_clr = 1'b0;
    q.delete();
    push_left = 0; n_out = 0; first_out = -1; last_out = -1;
    ret_cnt = 0; first_ret = -1; last_ret = -1;
    @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'd0,   1'b0, 8'd0,   1'b0};
    tbl[1] = '{1'b1, 8'd10,  1'b0, 8'd10,  1'b0};
    tbl[2] = '{1'b0, 8'd0,   1'b0, 8'd10,  1'b0};
    tbl[3] = '{1'b1, 8'd200, 1'b0, 8'd210, 1'b0};
    tbl[4] = '{1'b1, 8'd100, 1'b0, 8'd255, 1'b1};
    tbl[5] = '{1'b1, 8'd50,  1'b1, 8'd255, 1'b1};
    tbl[6] = '{1'b0, 8'd0,   1'b1, 8'd255, 1'b0};
    tbl[7] = '{1'b0, 8'd0,   1'b0, 8'd255, 1'b0};
    tbl[8] = '{1'b1, 8'd1,   1'b0, 8'd255, 1'b1};
    tbl[9] = '{1'b0, 8'd0,   1'b1, 8'd255, 1'b0};

    reset_n = 1'b0; avsi_valid = 1'b0; update_credit = 1'b0; credit = '0; err_clr = 1'b0;
    set_beat(0);
    do_reset();
    cyc();
    chk("ready_after_reset", 144'(avsi_ready), 144'd1);

    // Credit arithmetic, clamp and sticky overflow
    for (int i = 0; i < 10; i++) begin
      update_credit = tbl[i].upd;
      credit        = tbl[i].cr;
      err_clr       = tbl[i].clr;
      cyc();
      chk($sformatf("tbl%0d_count", i), 144'(credit_count), 144'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_ovf", i), 144'(credit_ovf), 144'(tbl[i].exp_ovf));
    end
    update_credit = 1'b0; err_clr = 1'b0;

    // No credit holds beats; grant of 2 releases exactly two back-to-back
    do_reset();
    set_beat(seq); push_left = 3; avsi_valid = 1'b1;
    repeat (8) cyc();
    chk("nocredit_out", 144'(n_out), 144'd0);
    chk("nocredit_level", 144'(fifo_level), 144'd3);
    update_credit = 1'b1; credit = 8'd2;
    cyc();
    update_credit = 1'b0;
    repeat (6) cyc();
    chk("grant2_out", 144'(n_out), 144'd2);
    chk("grant2_consecutive", 144'(last_out - first_out), 144'd1);
    chk("grant2_count", 144'(credit_count), 144'd0);
    chk("grant2_level", 144'(fifo_level), 144'd1);

    // Grant and pop together from a balance of 1
    update_credit = 1'b1; credit = 8'd1;
    cyc();
    chk("gp_pre_count", 144'(credit_count), 144'd1);
    credit = 8'd3;
    cyc();
    update_credit = 1'b0;
    chk("gp_count", 144'(credit_count), 144'd3);
    chk("gp_level", 144'(fifo_level), 144'd0);
    cyc();
    chk("gp_out", 144'(n_out), 144'd3);

    // Idle return of 5 unused credits
    do_reset();
    cyc();
    update_credit = 1'b1; credit = 8'd5;
    cyc();
    g = cnum;
    update_credit = 1'b0;
    repeat (40) cyc();
    chk("idle_ret_pulses", 144'(ret_cnt), 144'd5);
    chk("idle_ret_consecutive", 144'(last_ret - first_ret), 144'd4);
    chk("idle_ret_start", 144'(first_ret - g), 144'd17);
    chk("idle_ret_count", 144'(credit_count), 144'd0);

    // Fill to depth without credit, then drain 40 beats
    do_reset();
    set_beat(seq); push_left = 40; avsi_valid = 1'b1;
    repeat (40) cyc();
    chk("fill_accepted", 144'(q.size()), 144'd32);
    chk("fill_level", 144'(fifo_level), 144'd32);
    chk("fill_ready", 144'(avsi_ready), 144'd0);
    update_credit = 1'b1; credit = 8'd40;
    cyc();
    update_credit = 1'b0;
    for (int i = 0; i < 200 && n_out < 40; i++) cyc();
    chk("drain_out", 144'(n_out), 144'd40);
    chk("drain_queue", 144'(q.size()), 144'd0);
    chk("drain_pushleft", 144'(push_left), 144'd0);
    chk("drain_level", 144'(fifo_level), 144'd0);
    chk("drain_count", 144'(credit_count), 144'd0);

    // Reset with 10 beats buffered
    do_reset();
    set_beat(seq); push_left = 10; avsi_valid = 1'b1;
    repeat (14) cyc();
    chk("pre_rst_level", 144'(fifo_level), 144'd10);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    q.delete(); n_out = 0; push_left = 0; avsi_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) cyc();
    chk("post_rst_out", 144'(n_out), 144'd0);
    chk("post_rst_ready", 144'(avsi_ready), 144'd1);
    update_credit = 1'b1; credit = 8'd1;
    cyc();
    update_credit = 1'b0;
    set_beat(seq); push_left = 1; avsi_valid = 1'b1;
    repeat (5) cyc();
    chk("post_rst_new_out", 144'(n_out), 144'd1);
    chk("latency", 144'(last_out - last_acc), 144'd1);
    chk("post_rst_count", 144'(credit_count), 144'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
